// File: rtl/out_mem_streamer.sv
// Streams a block of 32-bit words out of OutMem as a byte stream, LSB first.
// One word in flight at a time: READ -> WAIT -> SEND (4 bytes) per word.
module out_mem_streamer #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = length;
          state_d     = (length != '0) ? StRead : StDone;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        word_d     = rd_data;
        byte_idx_d = 2'd0;
        state_d    = StSend;
      end
      StSend: begin
        if (out_ready) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            // Compare the old count against 1 so the full 2^LEN_W-1 range never wraps.
            remaining_d = remaining_q - LEN_W'(1);
            addr_d      = addr_q + ADDR_W'(1);
            byte_idx_d  = 2'd0;
            state_d     = (remaining_q != LEN_W'(1)) ? StRead : StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_idx_q  <= 2'd0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
    end
  end

  // Outputs decode straight from registered state so they never glitch on inputs.
  assign rd_en     = (state_q == StRead);
  assign rd_addr   = addr_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = word_q[8*byte_idx_q +: 8];
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule
